wired_rob_ptr: RTL and testbench

//  ROB slot allocator and head tracker; sits between rename/dispatch and wired_rob.

---
 rtl/wired_rob_ptr_if.sv | 25 ++
 rtl/wired_rob_ptr.sv | 74 +++++++
 tb/tb_wired_rob_ptr.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/wired_rob_ptr_if.sv
// Dispatch/commit-side handshake bundle for the ROB pointer allocator.
// The master drives alloc, retire and flush requests; the slave returns ids, ready and occupancy.
interface wired_rob_ptr_if #(
    parameter int ROB_LEN = 5
);
    logic [1:0]           a_valid_i;
    logic                 a_ready_o;
    logic [2*ROB_LEN-1:0] a_rob_id_o;
    logic [2*ROB_LEN-1:0] c_rrrid_o;
    logic [1:0]           c_retire_i;
    logic                 flush_i;
    logic [ROB_LEN:0]     count_o;
    logic                 empty_o;
    logic                 flushing_o;

    modport master (
        output a_valid_i, c_retire_i, flush_i,
        input  a_ready_o, a_rob_id_o, c_rrrid_o, count_o, empty_o, flushing_o
    );

    modport slave (
        input  a_valid_i, c_retire_i, flush_i,
        output a_ready_o, a_rob_id_o, c_rrrid_o, count_o, empty_o, flushing_o
    );
endinterface

// File: rtl/wired_rob_ptr.sv
// ROB slot allocator and head tracker: hands out tail/tail+1 ids to dispatch,
// exposes head/head+1 to commit, and drains the ROB to empty after a flush.
module wired_rob_ptr #(
    parameter int ROB_LEN = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    wired_rob_ptr_if.slave rob
);
    localparam int DEPTH = 1 << ROB_LEN;

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ROB_LEN-1:0] r_head;
    logic [ROB_LEN-1:0] r_tail;
    logic [ROB_LEN:0]   r_count;

    logic [ROB_LEN:0]   w_free;
    logic               w_ready;
    logic [1:0]         w_alloc_n;
    logic [1:0]         w_ret_n;
    logic [ROB_LEN:0]   w_count_after_ret;
    logic [ROB_LEN-1:0] w_tail_p1;
    logic [ROB_LEN-1:0] w_head_p1;

    // Allocation is granted in pairs only, so a single free slot already reads as full.
    assign w_free            = (ROB_LEN+1)'(DEPTH) - r_count;
    assign w_ready           = (r_state == RUN) && !rob.flush_i && (w_free >= (ROB_LEN+1)'(2));
    assign w_alloc_n         = w_ready ? ({1'b0, rob.a_valid_i[0]} + {1'b0, rob.a_valid_i[1]}) : 2'd0;
    assign w_ret_n           = {1'b0, rob.c_retire_i[0]} + {1'b0, rob.c_retire_i[1]};
    assign w_count_after_ret = r_count - (ROB_LEN+1)'(w_ret_n);
    assign w_tail_p1         = r_tail + ROB_LEN'(1);
    assign w_head_p1         = r_head + ROB_LEN'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (rob.flush_i) w_state_nxt = DRAIN;
            DRAIN:   if (w_count_after_ret == '0) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= r_head + ROB_LEN'(w_ret_n);
            r_tail  <= r_tail + ROB_LEN'(w_alloc_n);
            r_count <= w_count_after_ret + (ROB_LEN+1)'(w_alloc_n);
        end
    end

    assign rob.a_ready_o  = w_ready;
    assign rob.a_rob_id_o = {w_tail_p1, r_tail};
    assign rob.c_rrrid_o  = {w_head_p1, r_head};
    assign rob.count_o    = r_count;
    assign rob.empty_o    = (r_count == '0);
    assign rob.flushing_o = (r_state == DRAIN);

    // Upstream contract: slot1 never without slot0, and commit never retires past the tail.
    a_valid_pair: assert property (@(posedge clk) disable iff (!rst_n) rob.a_valid_i != 2'b10);
    c_retire_pair: assert property (@(posedge clk) disable iff (!rst_n) rob.c_retire_i != 2'b10);
    c_retire_le_count: assert property (@(posedge clk) disable iff (!rst_n)
        (ROB_LEN+1)'(w_ret_n) <= r_count);
    ptr_count_inv: assert property (@(posedge clk) disable iff (!rst_n)
        ((r_tail - r_head) == r_count[ROB_LEN-1:0]) && (r_count <= (ROB_LEN+1)'(DEPTH)));
endmodule

// File: tb/tb_wired_rob_ptr.sv
// Scoreboard bench for wired_rob_ptr: a behavioural pointer model predicts every cycle's outputs.
module tb_wired_rob_ptr;
    localparam int ROB_LEN = 5;
    localparam int DEPTH   = 1 << ROB_LEN;

    typedef struct {
        int ready;
        int ids;
        int rr;
        int count;
        int empty;
        int flushing;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    int m_head, m_tail, m_count;
    bit m_drain;

    wired_rob_ptr_if #(.ROB_LEN(ROB_LEN)) rif ();

    wired_rob_ptr #(.ROB_LEN(ROB_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rob   (rif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pair(input int hi, input int lo);
        return ((hi % DEPTH) << ROB_LEN) | (lo % DEPTH);
    endfunction

    task automatic model_reset();
        m_head = 0; m_tail = 0; m_count = 0; m_drain = 0;
    endtask

    task automatic cycle(input logic [1:0] v, input logic [1:0] r, input logic f);
        exp_t e, o;
        int   nalloc, nret;
        @(negedge clk);
        rif.a_valid_i  = v;
        rif.c_retire_i = r;
        rif.flush_i    = f;
        e.ready    = (!m_drain && !f && (DEPTH - m_count >= 2)) ? 1 : 0;
        e.ids      = pair(m_tail + 1, m_tail);
        e.rr       = pair(m_head + 1, m_head);
        e.count    = m_count;
        e.empty    = (m_count == 0) ? 1 : 0;
        e.flushing = m_drain ? 1 : 0;
        sb_q.push_back(e);
        #1;
        o = sb_q.pop_front();
        chk("a_ready_o",  int'(rif.a_ready_o),  o.ready);
        chk("a_rob_id_o", int'(rif.a_rob_id_o), o.ids);
        chk("c_rrrid_o",  int'(rif.c_rrrid_o),  o.rr);
        chk("count_o",    int'(rif.count_o),    o.count);
        chk("empty_o",    int'(rif.empty_o),    o.empty);
        chk("flushing_o", int'(rif.flushing_o), o.flushing);
        nalloc = (o.ready != 0) ? (int'(v[0]) + int'(v[1])) : 0;
        nret   = int'(r[0]) + int'(r[1]);
        if (m_drain) begin
            if (m_count - nret == 0) m_drain = 0;
        end else if (f) begin
            m_drain = 1;
        end
        m_tail  = (m_tail + nalloc) % DEPTH;
        m_head  = (m_head + nret) % DEPTH;
        m_count = m_count + nalloc - nret;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        rif.a_valid_i  = 2'b00;
        rif.c_retire_i = 2'b00;
        rif.flush_i    = 1'b0;
        @(negedge clk);
        #1;
        model_reset();
        chk("rst count_o",    int'(rif.count_o),    0);
        chk("rst empty_o",    int'(rif.empty_o),    1);
        chk("rst flushing_o", int'(rif.flushing_o), 0);
        chk("rst a_ready_o",  int'(rif.a_ready_o),  1);
        chk("rst a_rob_id_o", int'(rif.a_rob_id_o), pair(1, 0));
        chk("rst c_rrrid_o",  int'(rif.c_rrrid_o),  pair(1, 0));
        rst_n = 1'b1;
    endtask

    initial begin
        rif.a_valid_i  = 2'b00;
        rif.c_retire_i = 2'b00;
        rif.flush_i    = 1'b0;
        model_reset();
        do_reset();

        // Dual alloc after reset
        cycle(2'b11, 2'b00, 1'b0);
        chk("t1 ids slot pair", int'(rif.a_rob_id_o), 32);
        cycle(2'b00, 2'b00, 1'b0);
        chk("t1 count", int'(rif.count_o), 2);
        chk("t1 ids next", int'(rif.a_rob_id_o), 98);
        chk("t1 rrrid", int'(rif.c_rrrid_o), 32);

        // Fill to full with pairs
        for (int i = 0; i < 15; i++) cycle(2'b11, 2'b00, 1'b0);
        cycle(2'b11, 2'b00, 1'b0);
        chk("t2 full count", int'(rif.count_o), 32);
        chk("t2 full ready", int'(rif.a_ready_o), 0);
        cycle(2'b00, 2'b11, 1'b0);
        cycle(2'b00, 2'b00, 1'b0);
        chk("t2 count after retire", int'(rif.count_o), 30);
        chk("t2 ready after retire", int'(rif.a_ready_o), 1);

        // One free entry blocks pair allocation
        cycle(2'b01, 2'b00, 1'b0);
        cycle(2'b01, 2'b00, 1'b0);
        chk("t3 count 31", int'(rif.count_o), 31);
        chk("t3 ready one free", int'(rif.a_ready_o), 0);
        cycle(2'b00, 2'b01, 1'b0);
        cycle(2'b00, 2'b00, 1'b0);
        chk("t3 ready back", int'(rif.a_ready_o), 1);

        // Wrap of tail and head
        do_reset();
        cycle(2'b01, 2'b00, 1'b0);
        cycle(2'b11, 2'b00, 1'b0);
        for (int i = 0; i < 14; i++) cycle(2'b11, 2'b11, 1'b0);
        cycle(2'b11, 2'b00, 1'b0);
        chk("t4 ids at tail 31", int'(rif.a_rob_id_o), pair(0, 31));
        cycle(2'b00, 2'b11, 1'b0);
        chk("t4 ids after wrap", int'(rif.a_rob_id_o), pair(2, 1));
        cycle(2'b00, 2'b01, 1'b0);
        cycle(2'b00, 2'b01, 1'b0);
        chk("t4 rrrid head 31", int'(rif.c_rrrid_o), pair(0, 31));
        cycle(2'b00, 2'b00, 1'b0);
        chk("t4 rrrid head 0", int'(rif.c_rrrid_o), pair(1, 0));

        // Flush with 5 in flight, drain with allocation pressure and a repeated flush
        cycle(2'b11, 2'b00, 1'b0);
        cycle(2'b11, 2'b00, 1'b0);
        cycle(2'b11, 2'b00, 1'b1);
        chk("t5 count at flush", int'(rif.count_o), 5);
        chk("t5 ready in flush cycle", int'(rif.a_ready_o), 0);
        cycle(2'b11, 2'b11, 1'b0);
        chk("t5 flushing", int'(rif.flushing_o), 1);
        cycle(2'b11, 2'b11, 1'b1);
        cycle(2'b11, 2'b01, 1'b0);
        chk("t5 drain ready", int'(rif.a_ready_o), 0);
        cycle(2'b00, 2'b00, 1'b0);
        chk("t5 back to run", int'(rif.flushing_o), 0);
        chk("t5 empty", int'(rif.empty_o), 1);
        chk("t5 head==tail", int'(rif.c_rrrid_o), int'(rif.a_rob_id_o));
        chk("t5 ready after drain", int'(rif.a_ready_o), 1);

        // Simultaneous alloc+retire, then flush at empty
        for (int i = 0; i < 15; i++) cycle(2'b11, 2'b00, 1'b0);
        cycle(2'b11, 2'b11, 1'b0);
        chk("t6 count 30", int'(rif.count_o), 30);
        cycle(2'b00, 2'b00, 1'b0);
        chk("t6 count stays 30", int'(rif.count_o), 30);
        for (int i = 0; i < 15; i++) cycle(2'b00, 2'b11, 1'b0);
        cycle(2'b00, 2'b00, 1'b1);
        cycle(2'b00, 2'b00, 1'b0);
        chk("t6 drain one cycle", int'(rif.flushing_o), 1);
        cycle(2'b00, 2'b00, 1'b0);
        chk("t6 drain ended", int'(rif.flushing_o), 0);

        // Randomised legal traffic
        for (int i = 0; i < 300; i++) begin
            logic [1:0] v, r;
            logic       f;
            int         k;
            v = 2'($urandom_range(0, 2));
            if (v == 2'b10) v = 2'b11;
            k = $urandom_range(0, 2);
            if (k > m_count) k = m_count;
            r = (k == 2) ? 2'b11 : ((k == 1) ? 2'b01 : 2'b00);
            f = ($urandom_range(0, 19) == 0);
            cycle(v, r, f);
        end

        // Reset in the middle of a drain
        cycle(2'b11, 2'b00, 1'b0);
        cycle(2'b00, 2'b00, 1'b1);
        cycle(2'b00, 2'b00, 1'b0);
        do_reset();
        cycle(2'b00, 2'b00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
